// File: rtl/com_fw_to_sw.sv
`default_nettype none
// ============================================================================
// Module   : com_fw_to_sw
// Purpose  : Firmware-side command responder. It launches and times test-engine
//            runs, buffers readout words in a FIFO and reports a status word.
// Revision : 1.0 - initial release
// ============================================================================
module com_fw_to_sw #(
  parameter logic [3:0] FW_ID      = 4'b0001,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst_n,
  input  logic [3:0]  fw_dev_id_enable,
  input  logic        fw_op_code_w_reset,
  input  logic        fw_op_code_w_status_clear,
  input  logic        fw_op_code_w_execute,
  input  logic        fw_op_code_r_data_array_0,
  input  logic [23:0] sw_write24_0,
  input  logic [31:0] fw_data32,
  input  logic        fw_data_valid,
  output logic        fw_data_ready,
  output logic        fw_exec_start,
  input  logic        fw_exec_done,
  output logic [31:0] fw_read_data32,
  output logic [31:0] fw_read_status32
);

  localparam int              c_PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              c_CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FIFO_DEPTH);
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(FIFO_DEPTH - 1);
  localparam logic [1:0]      c_IDLE     = 2'd0;
  localparam logic [1:0]      c_BUSY     = 2'd1;
  localparam logic [3:0]      c_OP_RESET = 4'd1;
  localparam logic [3:0]      c_OP_CLEAR = 4'd2;
  localparam logic [3:0]      c_OP_EXEC  = 4'd3;
  localparam logic [3:0]      c_OP_READ  = 4'd4;

  logic [27:0]     r_cmd_prev;
  logic [1:0]      r_state,      w_state_nxt;
  logic [15:0]     r_tmo,        w_tmo_nxt;
  logic            r_exec_start, w_exec_start_nxt;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr,     w_wr_ptr_nxt;
  logic [c_PW-1:0] r_rd_ptr,     w_rd_ptr_nxt;
  logic [c_CW-1:0] r_count,      w_count_nxt;
  logic [31:0]     r_rd_data,    w_rd_data_nxt;
  logic            r_rd_valid,   w_rd_valid_nxt;
  logic [4:0]      r_sticky,     w_sticky_nxt;  // {exec_done, timeout, busy_reject, underflow, overflow}
  logic [7:0]      r_txn,        w_txn_nxt;
  logic [3:0]      r_last_op,    w_last_op_nxt;
  logic [31:0]     r_status,     w_status_nxt;

  logic        w_sel, w_cmd_new, w_empty, w_full, w_push, w_pop;
  logic        w_op_reset, w_op_clear, w_op_exec, w_op_read;
  logic [27:0] w_cmd_vec;

  assign w_sel     = (fw_dev_id_enable == FW_ID);
  assign w_cmd_vec = {fw_op_code_w_reset, fw_op_code_w_status_clear, fw_op_code_w_execute,
                      fw_op_code_r_data_array_0, sw_write24_0};
  assign w_cmd_new = w_sel && (w_cmd_vec != r_cmd_prev);

  assign w_op_reset = w_cmd_new && fw_op_code_w_reset;
  assign w_op_clear = w_cmd_new && !fw_op_code_w_reset && fw_op_code_w_status_clear;
  assign w_op_exec  = w_cmd_new && !fw_op_code_w_reset && !fw_op_code_w_status_clear
                      && fw_op_code_w_execute;
  assign w_op_read  = w_cmd_new && !fw_op_code_w_reset && !fw_op_code_w_status_clear
                      && !fw_op_code_w_execute && fw_op_code_r_data_array_0;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_push  = fw_data_valid && !w_full;
  assign w_pop   = w_op_read && !w_empty;

  always_comb begin
    w_state_nxt      = r_state;
    w_tmo_nxt        = r_tmo;
    w_exec_start_nxt = 1'b0;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_count_nxt      = r_count;
    w_rd_data_nxt    = r_rd_data;
    w_rd_valid_nxt   = r_rd_valid;
    w_sticky_nxt     = r_sticky;
    w_txn_nxt        = r_txn;
    w_last_op_nxt    = r_last_op;

    if (w_op_reset) begin
      // Soft reset mirrors the hard reset but records itself as the first transaction.
      w_state_nxt   = c_IDLE;
      w_tmo_nxt     = '0;
      w_wr_ptr_nxt  = '0;
      w_rd_ptr_nxt  = '0;
      w_count_nxt   = '0;
      w_rd_data_nxt = '0;
      w_rd_valid_nxt = 1'b0;
      w_sticky_nxt  = '0;
      w_txn_nxt     = 8'd1;
      w_last_op_nxt = c_OP_RESET;
    end else begin
      if (w_cmd_new) w_txn_nxt = r_txn + 8'd1;
      if (w_op_clear) begin
        w_sticky_nxt   = '0;
        w_rd_valid_nxt = 1'b0;
        w_last_op_nxt  = c_OP_CLEAR;
      end
      if (w_op_exec) w_last_op_nxt = c_OP_EXEC;
      if (w_op_read) w_last_op_nxt = c_OP_READ;

      if (r_state == c_BUSY) begin
        if (w_op_exec) w_sticky_nxt[2] = 1'b1;
        if (fw_exec_done) begin
          w_sticky_nxt[4] = 1'b1;
          w_state_nxt     = c_IDLE;
        end else if (r_tmo != 16'd0) begin
          w_tmo_nxt = r_tmo - 16'd1;
          if (r_tmo == 16'd1) begin
            w_sticky_nxt[3] = 1'b1;
            w_state_nxt     = c_IDLE;
          end
        end
      end else if (w_op_exec) begin
        w_exec_start_nxt = 1'b1;
        w_state_nxt      = c_BUSY;
        w_tmo_nxt        = sw_write24_0[15:0];
      end

      if (w_op_read) begin
        if (w_empty) begin
          w_rd_data_nxt   = '0;
          w_rd_valid_nxt  = 1'b0;
          w_sticky_nxt[1] = 1'b1;
        end else begin
          w_rd_data_nxt  = r_mem[r_rd_ptr];
          w_rd_valid_nxt = 1'b1;
          w_rd_ptr_nxt   = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
        end
      end
      if (fw_data_valid && w_full) w_sticky_nxt[0] = 1'b1;
      if (w_push) w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_push && !w_pop) w_count_nxt = r_count + 1'b1;
      if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
    end

    w_status_nxt = {FW_ID, w_last_op_nxt, w_txn_nxt, 5'(w_count_nxt),
                    (w_count_nxt == '0), (w_count_nxt == c_DEPTH), w_rd_valid_nxt,
                    1'b0, w_state_nxt, w_sticky_nxt};
  end

  always_ff @(posedge fw_axi_clk) begin
    if (fw_rst_n && w_push && !w_op_reset) r_mem[r_wr_ptr] <= fw_data32;
  end

  always_ff @(posedge fw_axi_clk) begin
    if (!fw_rst_n) begin
      r_cmd_prev   <= '0;
      r_state      <= c_IDLE;
      r_tmo        <= '0;
      r_exec_start <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_sticky     <= '0;
      r_txn        <= '0;
      r_last_op    <= '0;
      r_status     <= {FW_ID, 17'h0, 1'b1, 10'h0};
    end else begin
      r_cmd_prev   <= w_sel ? w_cmd_vec : 28'h0;
      r_state      <= w_state_nxt;
      r_tmo        <= w_tmo_nxt;
      r_exec_start <= w_exec_start_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_sticky     <= w_sticky_nxt;
      r_txn        <= w_txn_nxt;
      r_last_op    <= w_last_op_nxt;
      r_status     <= w_status_nxt;
    end
  end

  assign fw_data_ready    = !w_full;
  assign fw_exec_start    = r_exec_start;
  assign fw_read_data32   = r_rd_data;
  assign fw_read_status32 = r_status;

endmodule
`default_nettype wire

// File: tb/tb_com_fw_to_sw.sv
`default_nettype none
// ============================================================================
// Module   : tb_com_fw_to_sw
// Purpose  : Scoreboard bench for com_fw_to_sw against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_com_fw_to_sw;

  localparam logic [3:0] c_FW_ID = 4'b0001;
  localparam int         c_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en;
  logic        op_rst, op_clr, op_exe, op_rd;
  logic [23:0] body;
  logic [31:0] d32;
  logic        dvalid, done;
  logic        ready, start;
  logic [31:0] rdata, status;

  com_fw_to_sw #(.FW_ID(c_FW_ID), .FIFO_DEPTH(c_DEPTH)) dut (
    .fw_axi_clk                (clk),
    .fw_rst_n                  (rst_n),
    .fw_dev_id_enable          (en),
    .fw_op_code_w_reset        (op_rst),
    .fw_op_code_w_status_clear (op_clr),
    .fw_op_code_w_execute      (op_exe),
    .fw_op_code_r_data_array_0 (op_rd),
    .sw_write24_0              (body),
    .fw_data32                 (d32),
    .fw_data_valid             (dvalid),
    .fw_data_ready             (ready),
    .fw_exec_start             (start),
    .fw_exec_done              (done),
    .fw_read_data32            (rdata),
    .fw_read_status32          (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] st;
    logic [31:0] rd;
    logic        start;
    logic        ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  logic [31:0] m_fifo[$];
  logic [27:0] m_prev;
  logic        m_busy, m_start, m_rdv;
  int          m_tmo;
  logic        m_done, m_tout, m_br, m_uf, m_of;
  logic [31:0] m_data;
  int          m_txn, m_last;

  task automatic model_reset();
    m_busy = 0; m_tmo = 0; m_start = 0; m_rdv = 0; m_data = 0;
    m_done = 0; m_tout = 0; m_br = 0; m_uf = 0; m_of = 0;
    m_fifo.delete(); m_txn = 0; m_last = 0;
  endtask

  task automatic model_step();
    logic [27:0] vec;
    logic        nw, full;
    int          op;
    if (!rst_n) begin
      model_reset();
      m_prev = 0;
      return;
    end
    vec    = {op_rst, op_clr, op_exe, op_rd, body};
    nw     = (en == c_FW_ID) && (vec != m_prev);
    m_prev = (en == c_FW_ID) ? vec : 28'h0;
    op     = !nw ? 0 : op_rst ? 1 : op_clr ? 2 : op_exe ? 3 : op_rd ? 4 : 0;
    m_start = 0;
    if (op == 1) begin
      model_reset();
      m_last = 1;
      m_txn  = 1;
      return;
    end
    if (nw) m_txn = (m_txn + 1) % 256;
    if (op != 0) m_last = op;
    if (op == 2) begin
      m_done = 0; m_tout = 0; m_br = 0; m_uf = 0; m_of = 0; m_rdv = 0;
    end
    if (m_busy) begin
      if (op == 3) m_br = 1;
      if (done) begin
        m_done = 1; m_busy = 0;
      end else if (m_tmo != 0) begin
        m_tmo--;
        if (m_tmo == 0) begin m_tout = 1; m_busy = 0; end
      end
    end else if (op == 3) begin
      m_start = 1; m_busy = 1; m_tmo = int'(body[15:0]);
    end
    full = (m_fifo.size() == c_DEPTH);
    if (op == 4) begin
      if (m_fifo.size() == 0) begin
        m_data = 0; m_rdv = 0; m_uf = 1;
      end else begin
        m_data = m_fifo.pop_front(); m_rdv = 1;
      end
    end
    if (dvalid) begin
      if (full) m_of = 1;
      else m_fifo.push_back(d32);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = m_fifo.size();
    return {c_FW_ID, 4'(m_last), 8'(m_txn), 5'(n), (n == 0), (n == c_DEPTH), m_rdv,
            1'b0, 1'b0, m_busy, m_done, m_tout, m_br, m_uf, m_of};
  endfunction

  // Model predicts the post-edge outputs for the inputs now on the pins.
  task automatic tick();
    exp_t e;
    model_step();
    e.st    = model_status();
    e.rd    = m_data;
    e.start = m_start;
    e.ready = (m_fifo.size() != c_DEPTH);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("status", status, e.st);
      chk("read_data", rdata, e.rd);
      chk("exec_start", 32'(start), 32'(e.start));
      chk("data_ready", 32'(ready), 32'(e.ready));
    end
  end

  task automatic cmd(input logic r, input logic c, input logic x, input logic rd,
                     input logic [23:0] b);
    op_rst = r; op_clr = c; op_exe = x; op_rd = rd; body = b;
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      dvalid = 1; d32 = base + 32'(i);
      tick();
    end
    dvalid = 0;
  endtask

  task automatic reads(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) begin
      cmd(0, 0, 0, 1, base + 24'(i));
      tick();
    end
    cmd(0, 0, 0, 0, base);
  endtask

  initial begin
    rst_n = 0; en = c_FW_ID; cmd(0, 0, 0, 0, 0);
    d32 = 0; dvalid = 0; done = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();

    // timeout after 5 busy cycles
    cmd(0, 0, 1, 0, 24'h5); tick();
    cmd(0, 0, 0, 0, 24'h5); repeat (8) tick();

    // timeout disabled, done after ~100 cycles, second execute rejected
    cmd(0, 0, 1, 0, 24'h0); tick();
    cmd(0, 0, 0, 0, 24'h0); repeat (50) tick();
    cmd(0, 0, 1, 0, 24'h1); tick();
    cmd(0, 0, 0, 0, 24'h1); repeat (48) tick();
    done = 1; tick();
    done = 0; tick();

    // overflow, drain, underflow
    cmd(0, 1, 0, 0, 24'h0); tick();
    cmd(0, 0, 0, 0, 24'h0); tick();
    push_words(17, 32'h1);
    tick();
    reads(17, 24'h100);
    tick();

    // held read pops once; foreign device id ignored
    push_words(3, 32'hA0);
    cmd(0, 0, 0, 1, 24'h77); repeat (10) tick();
    en = 4'b0010;
    cmd(1, 1, 1, 1, 24'h55); repeat (2) tick();
    cmd(0, 0, 1, 0, 24'h03); repeat (2) tick();
    en = c_FW_ID;
    cmd(0, 0, 0, 0, 24'h78); tick();

    // simultaneous push/pop at full and at count 5
    reads(3, 24'h200);
    push_words(20, 32'hB00);
    dvalid = 1; d32 = 32'hDEAD; cmd(0, 0, 0, 1, 24'h300); tick();
    dvalid = 0; cmd(0, 0, 0, 0, 24'h300); tick();
    reads(10, 24'h400);
    dvalid = 1; d32 = 32'hBEEF; cmd(0, 0, 0, 1, 24'h500); tick();
    dvalid = 0; cmd(0, 0, 0, 0, 24'h500); tick();
    reads(6, 24'h600);

    // soft reset mid-busy with data buffered
    push_words(3, 32'hC0);
    cmd(0, 0, 1, 0, 24'd50); tick();
    cmd(0, 0, 0, 0, 24'd50); repeat (3) tick();
    cmd(1, 0, 0, 0, 24'h0); tick();
    cmd(0, 0, 0, 0, 24'h0); repeat (3) tick();

    // hard reset while busy
    cmd(0, 0, 1, 0, 24'd9); tick();
    rst_n = 0; tick();
    rst_n = 1; cmd(0, 0, 0, 0, 24'd9); repeat (12) tick();

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) begin
        int k;
        en = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : c_FW_ID;
        k = $urandom_range(0, 15);
        cmd(k == 0, k inside {1, 2}, k inside {[3:6]}, k >= 7,
            {8'($urandom), 16'($urandom_range(0, 12))});
        if ($urandom_range(0, 9) == 0) begin
          op_rst = ($urandom_range(0, 3) == 0); op_clr = 1'($urandom);
          op_exe = 1'($urandom); op_rd = 1'($urandom);
        end
      end
      dvalid = ($urandom_range(0, 3) == 0);
      d32    = $urandom;
      done   = ($urandom_range(0, 19) == 0);
      tick();
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/com_fw_to_sw.md
COM_FW_TO_SW -- requirements
Module: com_fw_to_sw

Interface
REQ-001 The block SHALL have parameter FW_ID, default 4'b0001, giving the one-hot device ID this responder answers to.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the readout FIFO depth in 32-bit words.
REQ-003 Ports SHALL be:
- fw_axi_clk  in  1  single clock; all logic rising-edge.
- fw_rst_n  in  1  synchronous, active-low reset.
- fw_dev_id_enable  in  4  one-hot device select.
- fw_op_code_w_reset  in  1  decoded soft-reset op.
- fw_op_code_w_status_clear  in  1  decoded status-clear op.
- fw_op_code_w_execute  in  1  decoded execute op.
- fw_op_code_r_data_array_0  in  1  decoded data-read op.
- sw_write24_0  in  24  command body.
- fw_data32  in  32  readout word from the test engine.
- fw_data_valid  in  1  fw_data32 qualifier.
- fw_data_ready  out  1  FIFO not full.
- fw_exec_start  out  1  one-cycle launch pulse to the test engine.
- fw_exec_done  in  1  one-cycle completion pulse from the test engine.
- fw_read_data32  out  32  data word to SW.
- fw_read_status32  out  32  status word to SW.

Function
REQ-004 The block SHALL treat sel = (fw_dev_id_enable == FW_ID).
REQ-005 The block SHALL form cmd_vec = {w_reset, w_status_clear, w_execute, r_data_array_0, sw_write24_0} (28 bits).
REQ-006 The block SHALL register cmd_prev each cycle as sel ? cmd_vec : 0.
REQ-007 The block SHALL raise cmd_new for one cycle when sel and cmd_vec != cmd_prev; SW re-issues an identical op by toggling a body bit.
REQ-008 On cmd_new with several op strobes high, priority SHALL be reset > status_clear > execute > read, and only the winner SHALL act.
REQ-009 w_reset SHALL have the same effect as fw_rst_n on all state except cmd_prev, effective the next cycle.
REQ-010 w_status_clear SHALL zero the sticky flags [4:0] and rd_valid, leaving the FIFO and FSM intact.
REQ-011 The FSM SHALL have two states: IDLE=2'd0 and BUSY=2'd1.
REQ-012 Execute in IDLE SHALL:
- pulse fw_exec_start in the next cycle;
- enter BUSY;
- load tmo_cnt = sw_write24_0[15:0].
REQ-013 Execute in BUSY SHALL set sticky busy_reject and SHALL NOT pulse fw_exec_start.
REQ-014 In BUSY, fw_exec_done SHALL set sticky exec_done and return to IDLE.
REQ-015 In BUSY with tmo_cnt != 0, tmo_cnt SHALL decrement each cycle.
REQ-016 On the decrement from 1 to 0 without fw_exec_done, the block SHALL set sticky timeout and return to IDLE.
REQ-017 If fw_exec_done coincides with expiry, done SHALL win and timeout SHALL stay clear.
REQ-018 A loaded tmo_cnt of 0 SHALL disable the timeout.
REQ-019 fw_exec_done in IDLE SHALL be ignored.
REQ-020 FIFO push SHALL occur when fw_data_valid && !full.
REQ-021 fw_data_valid && full SHALL drop the word and set sticky overflow.
REQ-022 fw_data_ready SHALL equal !full.
REQ-023 Read with FIFO non-empty SHALL pop the head into fw_read_data32 on the next cycle and set rd_valid.
REQ-024 Read with FIFO empty SHALL set fw_read_data32 = 0, clear rd_valid and set sticky underflow.
REQ-025 Simultaneous push and pop SHALL both occur, leaving the count unchanged; a push into a full FIFO SHALL NOT be rescued by a same-cycle pop.
REQ-026 The pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 The count SHALL range 0..FIFO_DEPTH.
REQ-028 fw_read_status32 SHALL be registered with this layout:
- [31:28] FW_ID;
- [27:24] last op (0 none, 1 reset, 2 clear, 3 execute, 4 read);
- [23:16] transaction counter, incremented per cmd_new, wrapping 255 -> 0;
- [15:11] FIFO count;
- [10] empty;
- [9] full;
- [8] rd_valid;
- [7] 0;
- [6:5] FSM state;
- [4] exec_done;
- [3] timeout;
- [2] busy_reject;
- [1] underflow;
- [0] overflow.
REQ-029 After a w_reset, the last op field SHALL read 1 and the transaction counter SHALL read 1.
REQ-030 fw_read_data32 SHALL hold its value until the next read op or reset.

Reset
REQ-031 While fw_rst_n = 0 at a clock edge, the block SHALL drive:
- fw_read_data32 = 0;
- fw_read_status32 = {FW_ID, 17'h0, 1'b1, 10'h0} (empty = 1);
- fw_exec_start = 0;
- fw_data_ready = 1;
- FSM = IDLE;
- FIFO empty;
- cmd_prev = 0.
REQ-032 Reset in BUSY SHALL abort without any fw_exec_start or timeout side effect.

Verification
REQ-033 Execute with body 0x000005 and no done -> one fw_exec_start pulse, BUSY for 5 cycles, then timeout = 1 and state = IDLE.
REQ-034 Execute with body 0x000000, then fw_exec_done after 100 cycles -> exec_done = 1, timeout = 0; a second execute while BUSY -> busy_reject = 1 and no second start.
REQ-035 Push 17 words 0x1..0x11 with no reads -> count = 16, full = 1, overflow = 1, fw_data_ready = 0; 16 reads return 0x1..0x10; a 17th read -> data 0 and underflow = 1.
REQ-036 Same read word held for 10 cycles -> exactly one pop; fw_dev_id_enable = 4'b0010 -> no action and status still reports FW_ID.
REQ-037 Push and pop in the same cycle at count = 16 -> the word is dropped with overflow set; at count = 5 -> count stays 5 and order is preserved.
REQ-038 w_reset issued mid-BUSY with FIFO count 3 -> next cycle: IDLE, FIFO empty, all stickies 0, last op = 1, transaction counter = 1.
